// File: rtl/data_type_pkg.sv
// Shared types for the pipelined floating-point multiplier: flag bundle,
// operand classes and the canonical quiet-NaN encoding for any exp/frac width.
package data_type_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_FRAC_W = 7;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Sign 0, exponent all ones, fraction MSB set; caller truncates to its width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
        logic [63:0] ones_v;
        ones_v = (64'd1 << exp_w) - 64'd1;
        return (ones_v << frac_w) | (64'd1 << (frac_w - 1));
    endfunction

endpackage

// File: rtl/fp_mul_norm.sv
// Final stage of fp_mul_pipe: normalise the significand product, round, detect
// exponent range limits and pack. Rounding is RNE with FP_MUL_RNE_EN, else truncate.
module fp_mul_norm
    import data_type_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                        sign,
    input  logic signed [EXP_W+1:0]     exp,
    input  logic [2*FRAC_W+1:0]         prod,
    input  fp_class_t                   cls,
    input  logic                        invalid,
    output logic [EXP_W+FRAC_W:0]       res,
    output fp_flags_t                   flags
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int P   = 2 * FRAC_W + 2;
    localparam int EW2 = EXP_W + 2;
    localparam logic [W-1:0]          QNAN    = W'(fp_qnan(EXP_W, FRAC_W));
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_MIN = {EW2{1'b0}};

    logic [P-1:0]            norm_s;
    logic [FRAC_W-1:0]       frac_s;
    logic [FRAC_W:0]         rem_s;
    logic                    round_up_s;
    logic [FRAC_W:0]         frac_rnd_s;
    logic signed [EW2-1:0]   exp_s;

    // Normalise so the leading one sits at P-1, round, then classify the exponent.
    always_comb begin
        norm_s     = prod[P-1] ? prod : {prod[P-2:0], 1'b0};
        frac_s     = norm_s[P-2 -: FRAC_W];
        rem_s      = norm_s[FRAC_W:0];
`ifdef FP_MUL_RNE_EN
        round_up_s = rem_s[FRAC_W] & ((|rem_s[FRAC_W-1:0]) | frac_s[0]);
`else
        round_up_s = 1'b0;
`endif
        frac_rnd_s = {1'b0, frac_s} + {{FRAC_W{1'b0}}, round_up_s};
        exp_s      = exp
                   + $signed({{(EW2-1){1'b0}}, prod[P-1]})
                   + $signed({{(EW2-1){1'b0}}, frac_rnd_s[FRAC_W]});

        res   = {W{1'b0}};
        flags = 4'b0000;
        case (cls)
            NAN: begin
                res           = QNAN;
                flags.invalid = invalid;
            end
            INF:  res = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ZERO: res = {sign, {(W-1){1'b0}}};
            NORM: begin
                if (exp_s >= EXP_MAX) begin
                    res            = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags.overflow = 1'b1;
                    flags.inexact  = 1'b1;
                end else if (exp_s <= EXP_MIN) begin
                    res             = {sign, {(W-1){1'b0}}};
                    flags.underflow = 1'b1;
                    flags.inexact   = 1'b1;
                end else begin
                    res           = {sign, exp_s[EXP_W-1:0], frac_rnd_s[FRAC_W-1:0]};
                    flags.inexact = |rem_s;
                end
            end
            default: res = QNAN;
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage valid/ready floating-point multiplier (classify, multiply, normalise).
// Define FP_MUL_RNE_EN for round-to-nearest-even; default build truncates.
module fp_mul_pipe
    import data_type_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+FRAC_W:0]    in_a,
    input  logic [EXP_W+FRAC_W:0]    in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_W:0]    out_res,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int M   = FRAC_W + 1;
    localparam int P   = 2 * M;
    localparam int EW2 = EXP_W + 2;
    localparam logic [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);

    function automatic fp_class_t classify(input logic [W-1:0] x);
        if (x[W-2:FRAC_W] == {EXP_W{1'b0}}) begin
            return ZERO;
        end else if (x[W-2:FRAC_W] == {EXP_W{1'b1}}) begin
            return (x[FRAC_W-1:0] == {FRAC_W{1'b0}}) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction

    logic             s1_valid_r, s2_valid_r, out_valid_r;
    logic             s1_sign_r, s2_sign_r;
    logic [EW2-1:0]   s1_exp_r, s2_exp_r;
    logic [M-1:0]     s1_ma_r, s1_mb_r;
    logic [P-1:0]     s2_prod_r;
    fp_class_t        s1_cls_r, s2_cls_r;
    logic             s1_invalid_r, s2_invalid_r;
    logic [TAG_W-1:0] s1_tag_r, s2_tag_r, out_tag_r;
    logic [W-1:0]     out_res_r;
    fp_flags_t        out_flags_r;

    fp_class_t        cls_a_s, cls_b_s, res_cls_s;
    logic             invalid_s;
    logic [EW2-1:0]   exp_sum_s;
    logic             load_out_s, load_s2_s, load_s1_s;
    logic [W-1:0]     norm_res_s;
    fp_flags_t        norm_flags_s;

    assign load_out_s = !out_valid_r || out_ready;
    assign load_s2_s  = !s2_valid_r || load_out_s;
    assign load_s1_s  = !s1_valid_r || load_s2_s;
    assign in_ready   = load_s1_s;

    // Resolve special operand combinations; NaN dominates, zero x inf is invalid.
    always_comb begin
        cls_a_s   = classify(in_a);
        cls_b_s   = classify(in_b);
        invalid_s = 1'b0;
        exp_sum_s = {2'b00, in_a[W-2:FRAC_W]} + {2'b00, in_b[W-2:FRAC_W]} - BIAS;
        if (cls_a_s == NAN || cls_b_s == NAN) begin
            res_cls_s = NAN;
        end else if ((cls_a_s == ZERO && cls_b_s == INF) || (cls_a_s == INF && cls_b_s == ZERO)) begin
            res_cls_s = NAN;
            invalid_s = 1'b1;
        end else if (cls_a_s == INF || cls_b_s == INF) begin
            res_cls_s = INF;
        end else if (cls_a_s == ZERO || cls_b_s == ZERO) begin
            res_cls_s = ZERO;
        end else begin
            res_cls_s = NORM;
        end
    end

    // Stage 1 register: classified operands with biased exponent sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= {EW2{1'b0}};
            s1_ma_r      <= {M{1'b0}};
            s1_mb_r      <= {M{1'b0}};
            s1_cls_r     <= ZERO;
            s1_invalid_r <= 1'b0;
            s1_tag_r     <= {TAG_W{1'b0}};
        end else if (load_s1_s) begin
            s1_valid_r   <= in_valid;
            s1_sign_r    <= in_a[W-1] ^ in_b[W-1];
            s1_exp_r     <= exp_sum_s;
            s1_ma_r      <= {1'b1, in_a[FRAC_W-1:0]};
            s1_mb_r      <= {1'b1, in_b[FRAC_W-1:0]};
            s1_cls_r     <= res_cls_s;
            s1_invalid_r <= invalid_s;
            s1_tag_r     <= in_tag;
        end
    end

    // Stage 2 register: full-width significand product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r   <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_exp_r     <= {EW2{1'b0}};
            s2_prod_r    <= {P{1'b0}};
            s2_cls_r     <= ZERO;
            s2_invalid_r <= 1'b0;
            s2_tag_r     <= {TAG_W{1'b0}};
        end else if (load_s2_s) begin
            s2_valid_r   <= s1_valid_r;
            s2_sign_r    <= s1_sign_r;
            s2_exp_r     <= s1_exp_r;
            s2_prod_r    <= {{M{1'b0}}, s1_ma_r} * {{M{1'b0}}, s1_mb_r};
            s2_cls_r     <= s1_cls_r;
            s2_invalid_r <= s1_invalid_r;
            s2_tag_r     <= s1_tag_r;
        end
    end

    fp_mul_norm #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_norm (
        .sign    (s2_sign_r),
        .exp     ($signed(s2_exp_r)),
        .prod    (s2_prod_r),
        .cls     (s2_cls_r),
        .invalid (s2_invalid_r),
        .res     (norm_res_s),
        .flags   (norm_flags_s)
    );

    // Output register; payload only changes when a valid result moves in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_res_r   <= {W{1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
            out_flags_r <= 4'b0000;
        end else if (load_out_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_res_r   <= norm_res_s;
                out_tag_r   <= s2_tag_r;
                out_flags_r <= norm_flags_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_tag   = out_tag_r;
    assign out_flags = out_flags_r;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (default 8/7/4 widths);
// rounding expectations follow FP_MUL_RNE_EN.
module tb_fp_mul_pipe;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_res;
    logic [3:0]  in_tag, out_tag, out_flags;
    int          checks, failures;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flags;
    } vec_t;
    vec_t vecs [0:12];

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                         output logic [15:0] res, output logic [3:0] flags,
                         output logic [3:0] tag_o, output int lat);
        res = 16'hxxxx; flags = 4'hx; tag_o = 4'hx; lat = 99;
        @(negedge clk);
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i; res = out_res; flags = out_flags; tag_o = out_tag;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = 16'h0000; in_b = 16'h0000; in_tag = 4'h0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (out_res !== 16'h0000) begin failures++; $display("FAIL reset_res got=%h exp=0000", out_res); end
        if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
        if (out_flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", out_flags); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic;
        logic [15:0] r; logic [3:0] f, t; int lat;
        issue(16'h4000, 16'h4040, 4'h7, r, f, t, lat);
        checks += 4;
        if (r !== 16'h40C0) begin failures++; $display("FAIL basic_res got=%h exp=40c0", r); end
        if (f !== 4'b0000) begin failures++; $display("FAIL basic_flags got=%b exp=0000", f); end
        if (t !== 4'h7) begin failures++; $display("FAIL basic_tag got=%h exp=7", t); end
        if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_vectors;
        logic [15:0] r; logic [3:0] f, t; int lat;
        vecs[0]  = '{16'hBF80, 16'h3F80, 16'hBF80, 4'b0000};
        vecs[1]  = '{16'h0080, 16'h0080, 16'h0000, 4'b0011};
        vecs[2]  = '{16'h8080, 16'h0080, 16'h8000, 4'b0011};
        vecs[3]  = '{16'h7F80, 16'hC000, 16'hFF80, 4'b0000};
        vecs[4]  = '{16'h8000, 16'h4000, 16'h8000, 4'b0000};
        vecs[5]  = '{16'h7F81, 16'h4000, 16'h7FC0, 4'b0000};
        vecs[6]  = '{16'h0001, 16'h4000, 16'h0000, 4'b0000};
        vecs[7]  = '{16'h7F00, 16'h4000, 16'h7F80, 4'b0101};
        vecs[8]  = '{16'h0000, 16'hFF80, 16'h7FC0, 4'b1000};
        vecs[10] = '{16'h4040, 16'h4040, 16'h4110, 4'b0000};
`ifdef FP_MUL_RNE_EN
        vecs[9]  = '{16'h3FC1, 16'h3FC1, 16'h4012, 4'b0001};
        vecs[11] = '{16'h3FD9, 16'h3F97, 16'h4000, 4'b0001};
        vecs[12] = '{16'h7F59, 16'h3F97, 16'h7F80, 4'b0101};
`else
        vecs[9]  = '{16'h3FC1, 16'h3FC1, 16'h4011, 4'b0001};
        vecs[11] = '{16'h3FD9, 16'h3F97, 16'h3FFF, 4'b0001};
        vecs[12] = '{16'h7F59, 16'h3F97, 16'h7F7F, 4'b0001};
`endif
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].a, vecs[i].b, 4'(i), r, f, t, lat);
            checks += 4;
            if (r !== vecs[i].res) begin failures++; $display("FAIL vec%0d_res got=%h exp=%h", i, r, vecs[i].res); end
            if (f !== vecs[i].flags) begin failures++; $display("FAIL vec%0d_flags got=%b exp=%b", i, f, vecs[i].flags); end
            if (t !== 4'(i)) begin failures++; $display("FAIL vec%0d_tag got=%h exp=%h", i, t, 4'(i)); end
            if (lat !== 3) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bq [0:3];
        logic [15:0] eq [0:3];
        logic [15:0] res_q [$];
        logic [3:0]  tag_q [$];
        int          cyc_q [$];
        bq = '{16'h3F80, 16'h4040, 16'hC000, 16'h3FC0};
        eq = '{16'h4000, 16'h40C0, 16'hC080, 16'h4040};
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (cyc < 4);
            in_a      = 16'h4000;
            in_b      = bq[cyc < 4 ? cyc : 0];
            in_tag    = 4'(cyc);
            #1;
            if (out_valid) begin res_q.push_back(out_res); tag_q.push_back(out_tag); cyc_q.push_back(cyc); end
        end
        in_valid = 1'b0;
        checks++;
        if (res_q.size() !== 4) begin
            failures++; $display("FAIL b2b_count got=%0d exp=4", res_q.size());
        end else begin
            checks += 2;
            if (cyc_q[0] !== 3) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=3", cyc_q[0]); end
            if (cyc_q[3] - cyc_q[0] !== 3) begin failures++; $display("FAIL b2b_throughput got=%0d exp=3", cyc_q[3] - cyc_q[0]); end
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (res_q[i] !== eq[i]) begin failures++; $display("FAIL b2b_res%0d got=%h exp=%h", i, res_q[i], eq[i]); end
                if (tag_q[i] !== 4'(i)) begin failures++; $display("FAIL b2b_tag%0d got=%h exp=%h", i, tag_q[i], 4'(i)); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] res_q [$];
        logic [3:0]  tag_q [$];
        logic [15:0] hold_res;
        logic [3:0]  hold_tag;
        logic        hold_seen, hold_bad;
        int          sent, drop_at;
        sent = 0; drop_at = -1; hold_seen = 1'b0; hold_bad = 1'b0;
        hold_res = 16'h0000; hold_tag = 4'h0;
        for (int cyc = 0; cyc < 40 && tag_q.size() < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (sent < 5);
            in_a      = 16'h3F80;
            in_b      = 16'h4000 + 16'(sent * 16);
            in_tag    = 4'(sent);
            #1;
            if (out_valid && !out_ready) begin
                if (!hold_seen) begin
                    hold_seen = 1'b1; hold_res = out_res; hold_tag = out_tag;
                end else if (out_res !== hold_res || out_tag !== hold_tag) begin
                    hold_bad = 1'b1;
                end
            end
            if (out_valid && out_ready) begin res_q.push_back(out_res); tag_q.push_back(out_tag); end
            if (!in_ready && drop_at < 0) drop_at = sent;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks += 4;
        if (drop_at !== 3) begin failures++; $display("FAIL bp_ready_drop got=%0d exp=3", drop_at); end
        if (sent !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", sent); end
        if (!hold_seen || hold_bad) begin failures++; $display("FAIL bp_hold got=seen%0b_changed%0b exp=seen1_changed0", hold_seen, hold_bad); end
        if (tag_q.size() !== 5) begin
            failures++; $display("FAIL bp_count got=%0d exp=5", tag_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks += 2;
                if (tag_q[i] !== 4'(i)) begin failures++; $display("FAIL bp_tag%0d got=%h exp=%h", i, tag_q[i], 4'(i)); end
                if (res_q[i] !== 16'h4000 + 16'(i * 16)) begin failures++; $display("FAIL bp_res%0d got=%h exp=%h", i, res_q[i], 16'h4000 + 16'(i * 16)); end
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [15:0] r; logic [3:0] f, t; int lat, ghosts;
        ghosts = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1;
            in_a = 16'h4000; in_b = 16'h4040; in_tag = 4'hA + 4'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        if (out_res !== 16'h0000) begin failures++; $display("FAIL midrst_res got=%h exp=0000", out_res); end
        repeat (2) @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        checks++;
        if (ghosts !== 0) begin failures++; $display("FAIL midrst_ghosts got=%0d exp=0", ghosts); end
        issue(16'h4000, 16'h4040, 4'h5, r, f, t, lat);
        checks += 3;
        if (r !== 16'h40C0) begin failures++; $display("FAIL midrst_new_res got=%h exp=40c0", r); end
        if (t !== 4'h5) begin failures++; $display("FAIL midrst_new_tag got=%h exp=5", t); end
        if (lat !== 3) begin failures++; $display("FAIL midrst_new_latency got=%0d exp=3", lat); end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset;
        test_basic;
        test_vectors;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent width in bits.
REQ-002 SHALL have parameter FRAC_W, default 7: stored fraction width in bits, without the hidden bit.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 SHALL have these ports; W = 1+EXP_W+FRAC_W.
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands
- in_a  in  W  operand A {sign, exp, frac}
- in_b  in  W  operand B {sign, exp, frac}
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_res  out  W  product
- out_tag  out  TAG_W  tag of this product
- out_flags  out  4  {invalid, overflow, underflow, inexact}

Function
REQ-005 SHALL be a 3-stage pipeline:
- S1: unpack, classify, exponent sum.
- S2: (FRAC_W+1)x(FRAC_W+1) significand product.
- S3: normalise, round, pack.
REQ-006 SHALL transfer on in_valid&&in_ready and on out_valid&&out_ready.
REQ-007 SHALL have a latency of exactly 3 cycles from accept to out_valid when there is no backpressure.
REQ-008 SHALL let stage k load when it is empty or stage k+1 loads that cycle; in_ready = !S1.valid || S1 advances.
REQ-009 SHALL sustain one result per cycle while out_ready=1.
REQ-010 SHALL hold out_res, out_tag and out_flags stable while out_valid=1 and out_ready=0.
REQ-011 SHALL set sign = sign_a XOR sign_b for every result, including zero and inf.
REQ-012 SHALL compute the exponent as exp_a + exp_b - bias + norm_carry, where bias = 2^(EXP_W-1)-1, in EXP_W+2-bit signed arithmetic.
REQ-013 SHALL handle an exponent >= 2^EXP_W-1 by outputting inf (exp all ones, frac 0) and setting overflow and inexact.
REQ-014 SHALL handle an exponent <= 0 by flushing the output to signed zero and setting underflow and inexact.
REQ-015 SHALL treat subnormal inputs (exp=0) as zero.
REQ-016 SHALL handle special operands as follows:
- Either operand NaN, or zero x inf: output canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0).
- zero x inf also sets invalid.
- inf x finite nonzero: output inf.
- zero x finite: output zero.
- No special case sets overflow, underflow or inexact.
REQ-017 SHALL set inexact whenever discarded product bits are nonzero.
REQ-018 SHALL account for round-up carry out of the fraction by incrementing the exponent, then re-applying the REQ-013 check.

Reset
REQ-019 SHALL on rst=1 immediately clear all stage valids, out_valid, out_res, out_tag and out_flags to 0.
REQ-020 SHALL drive in_ready=1 from the first cycle after rst deasserts.
REQ-021 SHALL discard all in-flight operations on a mid-operation reset; no result for them is ever emitted.

Configuration
REQ-022 SHALL round to nearest, ties to even (guard/round/sticky), when FP_MUL_RNE_EN is defined.
REQ-023 SHALL round toward zero (truncate) when FP_MUL_RNE_EN is undefined; inexact is still computed from the discarded bits.

Structure
REQ-024 SHALL place these in data_type_pkg, parametrised by EXP_W and FRAC_W:
- flag struct fp_flags_t
- operand class enum (ZERO, NORM, INF, NAN)
- canonical-NaN constant function
REQ-025 SHALL contain one sub-module, fp_mul_norm, holding the S3 normalise/round/pack logic.
REQ-026 SHALL keep all pipeline registers, including stage-valid and handshake logic, in fp_mul_pipe.

Verification (defaults; results in hex)
REQ-027 SHALL cover a basic product: in_a=0x4000, in_b=0x4040, out_ready=1 -> 3 cycles later out_res=0x40C0, out_flags=0.
REQ-028 SHALL cover rounding: in_a=in_b=0x3FC1.
- With FP_MUL_RNE_EN: out_res=0x4012, inexact=1.
- Without FP_MUL_RNE_EN: out_res=0x4011, inexact=1.
REQ-029 SHALL cover overflow and invalid, each checked independently of the other:
- 0x7F00 x 0x4000 -> out_res=0x7F80, overflow=1, inexact=1.
- 0x0000 x 0xFF80 -> out_res=0x7FC0, invalid=1.
REQ-030 SHALL cover backpressure: 5 back-to-back ops with tags 0..4, out_ready=0 for 6 cycles then 1.
- in_ready falls after 3 accepts.
- Results emerge in tag order 0..4 with no loss or duplication.
REQ-031 SHALL cover reset mid-stream: assert rst with 3 ops in flight -> out_valid=0 immediately; none of those ops ever appears at the output; a new op after reset completes normally.
